smooth_filter: RTL and testbench
================================

# smooth_filter

Streaming 3x3 programmable-kernel smoothing filter for 8-bit grayscale images in raster order. Sits between a pixel source and a pixel sink in the image pipeline. It consumes one pixel per input strobe and emits one filtered pixel per input strobe, using zero padding at the frame borders. Two internal line buffers form the 3x3 window; the kernel is nine unsigned coefficients, writable at runtime.

## Interface
- IMG_W, 256: pixels per line (power of 2).
- IMG_H, 256: lines per frame.
- KSHIFT, 4: right shift applied to the weighted sum (normalisation).
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-high: asserted when 1, despite the name.
- i_strb  in  1  input pixel valid, one-cycle qualifier; back-to-back or sparse.
- i_data  in  8  input pixel; ignored when i_strb=0.
- o_strb  out  1  output pixel valid, one-cycle pulse.
- o_data  out  8  filtered pixel; holds its last value when o_strb=0.
- kernel_write  in  1  coefficient write enable.
- kernel_idx  in  4  coefficient index 0..8; 9..15 ignored.
- kernel_data  in  8  unsigned coefficient value.

## Operation
- Coefficient index = 3*i+j, with i the row (0 = top) and j the column (0 = left) of the window.
- Output pixel (r,c) = sum over i,j of k[3i+j]*p(r-1+i, c-1+j).
  - Pixels outside the frame count as 0.
  - Sum width is 20 bits unsigned.
  - Result = (sum + 2^(KSHIFT-1)) >> KSHIFT, then saturated to 255.
- Default kernel, also loaded on reset: 1 2 1 / 2 4 2 / 1 2 1.
- Position tracking:
  - Input row/column counters advance per i_strb and wrap at IMG_W and IMG_H.
  - Frames are contiguous; there is no frame-start signal.
- Output ordering:
  - The output for pixel n is produced on input strobe n+IMG_W+1. That strobe may belong to the next frame.
  - The first IMG_W+1 strobes after reset produce no output.
  - Border masking uses the output pixel's own row/column, so next-frame pixels never leak into the current frame's last row.
  - The tail of the final frame is emitted only when further input arrives.
- Kernel writes:
  - kernel_write=1 with idx<=8 updates the coefficient at the clock edge.
  - The new value is used by every window multiplied after that edge.
  - Writes may coincide with i_strb and take effect for that pixel.

## Timing
- Latency is 2 clock edges:
  - The edge sampling i_strb updates the window.
  - The next edge registers the products.
  - The following edge registers o_data and sets o_strb.
- Fully pipelined: i_strb on consecutive cycles gives o_strb on consecutive cycles.
- Reset values: o_strb=0, o_data=0, counters=0, window=0, kernel=default. Line-buffer RAM contents need not be cleared; they are masked by the counters.
- Reset mid-frame:
  - o_strb is 0 in the cycle after reset.
  - In-flight pipeline results are discarded.
  - The next strobe is pixel (0,0), and the IMG_W+1 warm-up applies again.

## Configuration
- SMOOTHFILTER_KERNEL_WR_EN defined: the kernel write port is functional as described above.
- Undefined: coefficients are constants equal to the default kernel, kernel_* inputs are ignored, and the ports remain present.

## Structure
- Package smooth_filter_pkg holds:
  - IMG_W/IMG_H/KSHIFT defaults
  - the default kernel constant array
  - the coefficient type (8-bit unsigned) and the sum type (20-bit)
- Sub-module smooth_line_buffer: IMG_W x 8 single-port delay line, advanced on i_strb. Instantiated twice.

## Test plan
- Flat frame of all 100s, default kernel:
  - interior outputs 100
  - corner (0,0) = (900+8)>>4 = 56
  - top edge (0,5) = (1200+8)>>4 = 75
- Impulse of 160 at (10,10), rest 0: outputs at rows 9..11, columns 9..11 are 10 20 10 / 20 40 20 / 10 20 10; all others 0.
- Saturation, with SMOOTHFILTER_KERNEL_WR_EN: write all nine coefficients to 255, all-255 frame -> interior outputs 255.
- Identity kernel (k4=16, others 0): o_data equals the input pixel stream; the first output is pixel (0,0).
- Timing, strobes every 8 cycles:
  - no o_strb for the first 257 strobes
  - thereafter o_strb exactly 2 edges after each i_strb
  - 3 frames give 3*65536-257 outputs
- Reset asserted mid-frame for one cycle -> o_strb 0, kernel restored to default, next 257 strobes silent, then the new frame output starts at (0,0).

Source files
------------

// File: rtl/smooth_filter_pkg.sv
// Shared sizes, types and the power-on smoothing kernel for smooth_filter.
// Also holds the rounding/saturating normalisation used on the weighted sum.
package smooth_filter_pkg;

    localparam int IMG_W_DEF  = 256;
    localparam int IMG_H_DEF  = 256;
    localparam int KSHIFT_DEF = 4;

    typedef logic [7:0]  coef_t;
    typedef logic [15:0] prod_t;
    typedef logic [19:0] sum_t;
    typedef coef_t [8:0] kernel_t;

    // Index 3*i+j, row-major from the top-left tap; the kernel is symmetric.
    localparam kernel_t DEFAULT_KERNEL = {8'd1, 8'd2, 8'd1,
                                          8'd2, 8'd4, 8'd2,
                                          8'd1, 8'd2, 8'd1};

    function automatic logic [7:0] round_sat(input sum_t sum, input int shift);
        logic [20:0] r;
        r = ({1'b0, sum} + (21'd1 << (shift - 1))) >> shift;
        return (r > 21'd255) ? 8'hFF : r[7:0];
    endfunction

endpackage

// File: rtl/smooth_line_buffer.sv
// One-line delay for the 3x3 window: dout is the pixel written DEPTH strobes ago.
// Contents are not cleared on reset; the filter masks stale data by position.
module smooth_line_buffer
    import smooth_filter_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/smooth_filter.sv
// Streaming 3x3 weighted smoothing filter with zero padding, 2-edge latency after the window.
// SMOOTHFILTER_KERNEL_WR_EN enables runtime coefficient writes; otherwise the kernel is fixed.
module smooth_filter
    import smooth_filter_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int KSHIFT = KSHIFT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_strb,
    input  logic [7:0] i_data,
    output logic       o_strb,
    output logic [7:0] o_data,
    input  logic       kernel_write,
    input  logic [3:0] kernel_idx,
    input  logic [7:0] kernel_data
);

    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int WUW = $clog2(IMG_W + 2);
    localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
    localparam logic [WUW-1:0] WARM     = WUW'(IMG_W + 1);

    kernel_t coef;

`ifdef SMOOTHFILTER_KERNEL_WR_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            coef <= DEFAULT_KERNEL;
        end else if (kernel_write && kernel_idx <= 4'd8) begin
            coef[kernel_idx] <= kernel_data;
        end
    end
`else
    logic kernel_unused;
    assign coef          = DEFAULT_KERNEL;
    assign kernel_unused = ^{kernel_write, kernel_idx, kernel_data};
`endif

    logic [7:0] lb0_out, lb1_out;

    smooth_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (i_strb),
        .din  (i_data),
        .dout (lb0_out)
    );

    smooth_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (i_strb),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    // Right window column holds pixels n-2W, n-W, n; the centre is pixel n-W-1.
    logic [7:0]     win [3][3];
    logic           s1_valid;
    logic [CW-1:0]  s1_col, c_col;
    logic [RW-1:0]  s1_row, c_row;
    logic [WUW-1:0] warm;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
            s1_valid <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            c_col    <= '0;
            c_row    <= '0;
            warm     <= '0;
        end else begin
            s1_valid <= 1'b0;
            if (i_strb) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= lb1_out;
                win[1][2] <= lb0_out;
                win[2][2] <= i_data;
                if (warm != WARM) begin
                    warm <= warm + WUW'(1);
                end else begin
                    s1_valid <= 1'b1;
                    s1_col   <= c_col;
                    s1_row   <= c_row;
                    c_col    <= (c_col == COL_LAST) ? '0 : c_col + CW'(1);
                    if (c_col == COL_LAST) begin
                        c_row <= (c_row == ROW_LAST) ? '0 : c_row + RW'(1);
                    end
                end
            end
        end
    end

    // Zero padding is decided by the centre pixel's own position.
    logic [7:0] tap [3][3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                tap[i][j] = win[i][j];
                if ((i == 0 && s1_row == '0) || (i == 2 && s1_row == ROW_LAST) ||
                    (j == 0 && s1_col == '0) || (j == 2 && s1_col == COL_LAST)) begin
                    tap[i][j] = '0;
                end
            end
        end
    end

    prod_t prod [9];
    logic  s2_valid;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s2_valid <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                prod[k] <= '0;
            end
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        prod[3*i+j] <= prod_t'(tap[i][j]) * prod_t'(coef[3*i+j]);
                    end
                end
            end
        end
    end

    sum_t sum;

    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            sum = sum + sum_t'(prod[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            o_strb <= 1'b0;
            o_data <= '0;
        end else begin
            o_strb <= s2_valid;
            if (s2_valid) begin
                o_data <= round_sat(sum, KSHIFT);
            end
        end
    end

endmodule

// File: tb/tb_smooth_filter.sv
// Directed bench for smooth_filter on a reduced 8x6 frame with hand-computed expectations.
// Frame outputs are captured in order, then checked against a vector table and short sequences.
module tb_smooth_filter;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int KS   = 4;
    localparam int NPIX = W * H;
    localparam int CAP  = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_strb;
    logic [7:0] i_data;
    logic       o_strb;
    logic [7:0] o_data;
    logic       kernel_write;
    logic [3:0] kernel_idx;
    logic [7:0] kernel_data;

    always #5 clk = ~clk;

    smooth_filter #(.IMG_W(W), .IMG_H(H), .KSHIFT(KS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_strb      (i_strb),
        .i_data      (i_data),
        .o_strb      (o_strb),
        .o_data      (o_data),
        .kernel_write(kernel_write),
        .kernel_idx  (kernel_idx),
        .kernel_data (kernel_data)
    );

    typedef struct {
        int pat;
        int r;
        int c;
        int exp;
    } vec_t;

    vec_t       vt[$];
    int         n_vec;
    int         n_err;
    logic [7:0] cap [CAP];
    int         cap_idx;

    // Output capture; cleared while reset is held.
    always @(negedge clk) begin
        if (rst_n) begin
            cap_idx = 0;
        end else if (o_strb) begin
            if (cap_idx < CAP) cap[cap_idx] = o_data;
            cap_idx++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, expected finish well before", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 8'd100;
            1:       return (r == 2 && c == 3) ? 8'd160 : 8'd0;
            2:       return 8'((r * 37 + c * 11 + 5) & 255);
            3:       return 8'd255;
            default: return 8'd0;
        endcase
    endfunction

    task automatic add_vec(input int pat, input int r, input int c, input int exp);
        vec_t v;
        v.pat = pat;
        v.r   = r;
        v.c   = c;
        v.exp = exp;
        vt.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] d, input int gap);
        i_strb = 1'b1;
        i_data = d;
        tick();
        i_strb = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
    endtask

    task automatic write_k(input int idx, input int data);
        kernel_write = 1'b1;
        kernel_idx   = 4'(idx);
        kernel_data  = 8'(data);
        tick();
        kernel_write = 1'b0;
    endtask

    // One full frame, then W+1 strobes of next-frame data (77) to push out the tail.
    task automatic capture_frame(input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send_pixel(pix(pat, r, c), 0);
            end
        end
        repeat (W + 1) send_pixel(8'd77, 0);
        repeat (3) tick();
        check($sformatf("count pat%0d", pat), cap_idx, NPIX);
    endtask

    task automatic check_table(input int pat);
        foreach (vt[k]) begin
            if (vt[k].pat == pat) begin
                check($sformatf("pat%0d (%0d,%0d)", pat, vt[k].r, vt[k].c),
                      cap[vt[k].r * W + vt[k].c], vt[k].exp);
            end
        end
    endtask

    initial begin
        int nz;
        rst_n        = 1'b1;
        i_strb       = 1'b0;
        i_data       = '0;
        kernel_write = 1'b0;
        kernel_idx   = '0;
        kernel_data  = '0;
        n_vec        = 0;
        n_err        = 0;

        // flat 100, default kernel: corners 900, edges 1200, interior 1600 before >>4
        add_vec(0, 0, 0, 56);  add_vec(0, 0, 7, 56);  add_vec(0, 5, 0, 56);
        add_vec(0, 5, 7, 56);  add_vec(0, 0, 3, 75);  add_vec(0, 5, 3, 75);
        add_vec(0, 2, 0, 75);  add_vec(0, 2, 7, 75);  add_vec(0, 2, 3, 100);
        add_vec(0, 3, 4, 100);
        // impulse 160 at (2,3)
        add_vec(1, 1, 2, 10);  add_vec(1, 1, 3, 20);  add_vec(1, 1, 4, 10);
        add_vec(1, 2, 2, 20);  add_vec(1, 2, 3, 40);  add_vec(1, 2, 4, 20);
        add_vec(1, 3, 2, 10);  add_vec(1, 3, 3, 20);  add_vec(1, 3, 4, 10);
        add_vec(1, 0, 3, 0);   add_vec(1, 4, 3, 0);   add_vec(1, 2, 1, 0);
        add_vec(1, 2, 5, 0);
        // all-255 frame with all-255 kernel saturates everywhere
        add_vec(3, 0, 0, 255); add_vec(3, 2, 3, 255); add_vec(3, 5, 7, 255);
        add_vec(3, 0, 4, 255);

        repeat (3) tick();
        check("reset o_strb", o_strb, 0);
        check("reset o_data", o_data, 0);
        rst_n = 1'b0;

        capture_frame(0);
        check_table(0);
        check("o_data hold", o_data, 56);
        apply_reset();

        capture_frame(1);
        check_table(1);
        nz = 0;
        for (int k = 0; k < NPIX; k++) if (cap[k] != 8'd0) nz++;
        check("impulse nonzero count", nz, 9);
        apply_reset();

`ifdef SMOOTHFILTER_KERNEL_WR_EN
        for (int k = 0; k < 9; k++) write_k(k, (k == 4) ? 16 : 0);
        write_k(13, 200);
        capture_frame(2);
        for (int k = 0; k < NPIX; k++) begin
            check($sformatf("identity px%0d", k), cap[k], pix(2, k / W, k % W));
        end
        apply_reset();

        for (int k = 0; k < 9; k++) write_k(k, 255);
        capture_frame(3);
        check_table(3);
        apply_reset();
`else
        for (int k = 0; k < 9; k++) write_k(k, (k == 4) ? 16 : 0);
        capture_frame(0);
        check("fixed kernel corner", cap[0], 56);
        check("fixed kernel interior", cap[2 * W + 3], 100);
        apply_reset();
`endif

        // sparse strobes, one every 8 cycles, three frames
        for (int s = 0; s < 3 * NPIX; s++) begin
            i_strb = 1'b1;
            i_data = 8'd100;
            tick();
            i_strb = 1'b0;
            check($sformatf("timing e0 s%0d", s), o_strb, 0);
            tick();
            check($sformatf("timing e1 s%0d", s), o_strb, 0);
            tick();
            check($sformatf("timing e2 s%0d", s), o_strb, (s >= W + 1) ? 1 : 0);
            repeat (5) tick();
        end
        check("timing output count", cap_idx, 3 * NPIX - (W + 1));
        check("timing first output", cap[0], 56);

        // reset mid-frame with results in flight and a modified kernel
        apply_reset();
        write_k(4, 16);
        for (int k = 0; k < 20; k++) send_pixel(8'd100, 0);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        check("midreset o_strb e1", o_strb, 0);
        tick();
        check("midreset o_strb e2", o_strb, 0);
        tick();
        check("midreset o_strb e3", o_strb, 0);
        for (int k = 0; k < W + 1; k++) send_pixel(8'd100, 0);
        repeat (3) tick();
        check("midreset warmup silent", cap_idx, 0);
        for (int k = W + 1; k < NPIX; k++) send_pixel(8'd100, 0);
        repeat (W + 1) send_pixel(8'd77, 0);
        repeat (3) tick();
        check("midreset count", cap_idx, NPIX);
        check("midreset corner", cap[0], 56);
        check("midreset top edge", cap[5], 75);
        check("midreset interior", cap[2 * W + 3], 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
